// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC accelerator output stage.
//   FP_W     - floating-point word width
//   MAC_SIZE - default tile dimension (rows per column vector, columns per tile)
//   state_e  - collector FSM state encoding
package mac_pkg;

    localparam int FP_W     = 32;
    localparam int MAC_SIZE = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

endpackage

// File: rtl/mac_col_buffer.sv
// mac_col_buffer: SIZE x (SIZE*FP_W) result tile storage with a per-column
// valid mask.
//   clk, rstn  - clock, synchronous active-low reset (mask only)
//   we_i       - write the column vector wdata_i into column wcol_i
//   wcol_i     - write column index
//   wdata_i    - column vector, row r at [r*FP_W +: FP_W]
//   clr_i      - clear the whole valid mask
//   rcol_i     - read column
//   rrow_i     - read row
//   rdata_o    - word at {rcol_i,rrow_i}, zero when that column was never written
//   mask_o     - per-column written flags
module mac_col_buffer
    import mac_pkg::*;
#(
    parameter int SIZE = MAC_SIZE,
    localparam int CW  = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we_i,
    input  logic [CW-1:0]        wcol_i,
    input  logic [SIZE*FP_W-1:0] wdata_i,
    input  logic                 clr_i,
    input  logic [CW-1:0]        rcol_i,
    input  logic [CW-1:0]        rrow_i,
    output logic [FP_W-1:0]      rdata_o,
    output logic [SIZE-1:0]      mask_o
);

    logic [SIZE*FP_W-1:0] mem_q [SIZE];
    logic [SIZE-1:0]      mask_q, mask_d;
    logic [SIZE*FP_W-1:0] rd_col;

    // Storage carries no reset; the mask alone decides what is visible.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wcol_i] <= wdata_i;
    end

    // A same-cycle set wins over the global clear.
    always_comb begin
        mask_d = clr_i ? '0 : mask_q;
        if (we_i) mask_d[wcol_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) mask_q <= '0;
        else       mask_q <= mask_d;
    end

    assign rd_col  = mem_q[rcol_i];
    assign rdata_o = mask_q[rcol_i] ? rd_col[rrow_i*FP_W +: FP_W] : '0;
    assign mask_o  = mask_q;

endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: captures column-result vectors from the FP add
// column into a SIZE x SIZE tile and, on the tile's done beat, stalls the MAC
// pipeline and drains the tile column-major as a 32-bit valid/ready stream.
//   clk, rstn      - clock, synchronous active-low reset
//   add_in         - result vector, row r at [r*32 +: 32]
//   valid_in       - add_in valid
//   b_col_in       - destination column of add_in
//   done_in        - final beat of the tile (qualified by valid_in)
//   stall_out      - freeze request to upstream MAC stages (high while draining)
//   out_data       - drained word (zero outside the drain)
//   out_valid      - out_data valid
//   out_ready      - consumer accepts the word
//   out_last       - final word of the tile
//   err_incomplete - sticky: a tile closed with unwritten columns
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int SIZE = MAC_SIZE,
    localparam int CW  = $clog2(SIZE),
    localparam int IW  = $clog2(SIZE*SIZE)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SIZE*FP_W-1:0] add_in,
    input  logic                 valid_in,
    input  logic [CW-1:0]        b_col_in,
    input  logic                 done_in,
    output logic                 stall_out,
    output logic [FP_W-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 err_incomplete
);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            err_q;

    logic            draining;
    logic            wr_en;
    logic            hs;
    logic            last;
    logic            clr_mask;
    logic [SIZE-1:0] mask;
    logic [SIZE-1:0] col_oh;
    logic [FP_W-1:0] rdata;

    assign draining = (state_q == DRAIN);
    // Upstream holds its beat while frozen, so input is only sampled in COLLECT.
    assign wr_en    = !draining && valid_in;
    assign hs       = draining && out_ready;
    assign last     = draining && (idx_q == IW'(SIZE*SIZE-1));
    assign clr_mask = hs && last;
    assign col_oh   = {{(SIZE-1){1'b0}}, 1'b1} << b_col_in;

    mac_col_buffer #(.SIZE(SIZE)) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (wr_en),
        .wcol_i  (b_col_in),
        .wdata_i (add_in),
        .clr_i   (clr_mask),
        .rcol_i  (idx_q[IW-1:CW]),
        .rrow_i  (idx_q[CW-1:0]),
        .rdata_o (rdata),
        .mask_o  (mask)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (valid_in && done_in) begin
                        state_q <= DRAIN;
                        idx_q   <= '0;
                        // Include the done beat's own column in the completeness test.
                        if ((mask | col_oh) != {SIZE{1'b1}}) err_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last) begin
                            state_q <= COLLECT;
                            idx_q   <= '0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // All outputs decode from registers only; no input reaches stall_out.
    assign stall_out      = draining;
    assign out_valid      = draining;
    assign out_last       = last;
    assign out_data       = draining ? rdata : '0;
    assign err_incomplete = err_q;

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Output stage of the MAC accelerator, sitting directly downstream of the FP add column. It captures each valid column-result vector into a SIZE×SIZE result tile, indexed by the column tag travelling with the data. When the tile's done beat arrives, it freezes the MAC pipeline via `stall_out` and drains the tile as a 32-bit word stream with a valid/ready handshake.

## Interface
- `SIZE`, 16, rows per column vector and number of columns per tile; must be a power of two, ≥2.
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous active-low reset.
- `add_in`  in  SIZE*32  result vector from the add column; row r is `[r*32+:32]`.
- `valid_in`  in  1  `add_in` is valid this cycle.
- `b_col_in`  in  $clog2(SIZE)  destination column of `add_in`.
- `done_in`  in  1  marks the final beat of a tile; only meaningful with `valid_in`.
- `stall_out`  out  1  freeze request to all upstream MAC stages (drives their `stall`).
- `out_data`  out  32  drained result word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_last`  out  1  final word of the tile.
- `err_incomplete`  out  1  sticky flag: a tile was closed with unwritten columns.

## Operation
- States: COLLECT (reset) and DRAIN.
- COLLECT, beat accepted when `valid_in`=1:
  - `buf[b_col_in] <= add_in`.
  - `mask[b_col_in] <= 1`.
  - A second write to the same column overwrites; last write wins.
- COLLECT, beat with `valid_in && done_in`:
  - The write above is performed.
  - Go to DRAIN with `idx <= 0`.
  - If `(mask | onehot(b_col_in)) != all ones`, set `err_incomplete`.
- `done_in` without `valid_in` is ignored.
- DRAIN:
  - `idx` has width $clog2(SIZE*SIZE). Column = `idx[high bits]`, row = `idx[low $clog2(SIZE) bits]`; order is column-major, row 0 first.
  - `out_data` = `buf[col][row*32+:32]` if `mask[col]`, else 32'h0.
  - `out_valid`=1 throughout DRAIN.
  - `out_last`=1 when `idx == SIZE*SIZE-1`.
  - On `out_valid && out_ready`, `idx` increments.
  - On the handshake with `out_last`: return to COLLECT, `mask <= 0`.
- `stall_out` = (state == DRAIN), decoded from the state register with no combinational input path.
- Inputs arriving during DRAIN are not sampled. Upstream is frozen, so they are held and accepted in the first COLLECT cycle.
- `err_incomplete` clears only on reset.
- Reset, including mid-drain: state COLLECT, `mask` 0, `idx` 0, `err_incomplete` 0. `buf` contents need no reset.
- Reset values of outputs:
  - `stall_out`=0
  - `out_valid`=0
  - `out_last`=0
  - `out_data`=0
  - `err_incomplete`=0

## Timing
- Capture: the beat at edge T is written at T. It can be read in DRAIN from T+1.
- Done beat at edge T: `stall_out`=1 and `out_valid`=1 from the cycle after T. The first word (col 0, row 0) is presented in that cycle.
- Throughput: one word per cycle while `out_ready`=1, so the minimum drain is SIZE*SIZE cycles.
- `out_ready`=0: `out_data`/`out_last` stay stable and `idx` holds.
- Last handshake at edge L: `stall_out`=0 and `out_valid`=0 in the cycle after L. A held upstream beat is captured at edge L+1.
- No bubble is required between tiles beyond the drain itself.

## Structure
- Shared package `mac_pkg`:
  - FP word width (32).
  - State encoding (COLLECT=0, DRAIN=1).
  - `MAC_SIZE` default.
- Sub-module `mac_col_buffer`:
  - SIZE entries × SIZE*32 bits.
  - One write port (column-indexed).
  - One 32-bit read port addressed by {col,row}.
  - Valid mask with per-column set and global clear.
- FSM and counter live in the top.

## Test plan
All scenarios use SIZE=4 (16 words per drain).
- Write cols 0..3 in order, each row r of col c = 32'h3F800000+(c<<4)+r; done on col 3 with `out_ready`=1 → `stall_out` rises next cycle. 16 words appear in order c0r0..c3r3 with matching values. `out_last` on word 15. `stall_out` drops the cycle after. `err_incomplete`=0.
- Same tile with `out_ready` toggling 1,0,0,1… → words are never skipped or duplicated. `out_data` is stable across ready=0 cycles.
- Write col 2 twice (A then B), then cols 0,1,3 with done → col 2 drains B.
- Write only cols 0,1, done on col 1 → cols 2,3 drain as 32'h0. `err_incomplete`=1 and stays 1 through the next complete tile.
- Hold `valid_in`=1 with a new tile's col 0 during a drain → it is not written until the cycle after the last handshake. The next tile's drain shows the new col-0 value, and col 1..3 mask bits are clear.
- Assert `rstn`=0 at word 7 of a drain → next cycle `stall_out`=0, `out_valid`=0, `err_incomplete`=0. A following complete tile drains from word 0.
